// File: rtl/dvp_capture_pack.sv
// dvp_capture_pack
//   DVP camera capture front end in the PCLK domain. It registers the sensor
//   bus and discards SKIP_FRAMES whole frames after reset. It then packs
//   PIX_BYTES bus beats into one pixel word and emits that word with X/Y
//   coordinates, line and frame strobes, and a per-line length / error report.
//
// Ports
//   PCLK, Rst         pixel clock; synchronous active-high reset
//   Vsync, Href, Data raw DVP bus
//   Enable            capture enable, looked at only on the frame-start edge
//   DataValid         one-cycle pixel strobe; DataPixel holds the first beat in the MSBs
//   Xaddr, Yaddr      coordinates of the pixel on DataValid
//   DataHs, DataVs    line / frame activity, aligned with DataValid
//   FrameDone         one-cycle pulse at the end of a captured frame
//   LineErr           one-cycle pulse when a line ends with a partial pixel
//   LineLen           pixel count of the last completed line
//   State             0 IDLE, 1 SKIP, 2 ARMED, 3 CAPTURE
module dvp_capture_pack #(
  parameter int DATA_W         = 8,
  parameter int PIX_BYTES      = 1,
  parameter int SKIP_FRAMES    = 10,
  parameter int VS_ACTIVE_HIGH = 1,
  parameter int X_W            = 14,
  parameter int Y_W            = 14
) (
  input  logic                          PCLK,
  input  logic                          Rst,
  input  logic                          Vsync,
  input  logic                          Href,
  input  logic [DATA_W-1:0]             Data,
  input  logic                          Enable,
  output logic                          DataValid,
  output logic [PIX_BYTES*DATA_W-1:0]   DataPixel,
  output logic [X_W-1:0]                Xaddr,
  output logic [Y_W-1:0]                Yaddr,
  output logic                          DataHs,
  output logic                          DataVs,
  output logic                          FrameDone,
  output logic                          LineErr,
  output logic [X_W-1:0]                LineLen,
  output logic [1:0]                    State
);

  localparam int         PW        = PIX_BYTES * DATA_W;
  localparam logic [1:0] LAST_PH   = 2'(PIX_BYTES - 1);
  localparam logic [7:0] LAST_SKIP = 8'(SKIP_FRAMES - 1);
  // Reset value of the sampled Vsync that makes the polarity-corrected vs
  // read 0. The first real blanking edge is then seen as a vs rise.
  localparam logic       VS_RST    = (VS_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SKIP  = 2'd1,
    S_ARMED = 2'd2,
    S_CAPT  = 2'd3
  } state_e;

  // ---------------- input stage and edge detection ----------------
  logic              r_vsync_q, r_href_q, vs_q, href_q;
  logic [DATA_W-1:0] r_data_q;
  logic              vs, vs_rise, vs_fall, href_rise, href_fall;

  always_ff @(posedge PCLK) begin
    if (Rst) begin
      r_vsync_q <= VS_RST;
      r_href_q  <= 1'b0;
      r_data_q  <= '0;
      vs_q      <= 1'b0;
      href_q    <= 1'b0;
    end else begin
      r_vsync_q <= Vsync;
      r_href_q  <= Href;
      r_data_q  <= Data;
      vs_q      <= vs;
      href_q    <= r_href_q;
    end
  end

  assign vs        = (VS_ACTIVE_HIGH != 0) ? r_vsync_q : ~r_vsync_q;
  assign vs_rise   = vs & ~vs_q;
  assign vs_fall   = ~vs & vs_q;
  assign href_rise = r_href_q & ~href_q;
  assign href_fall = ~r_href_q & href_q;

  // ---------------- frame FSM ----------------
  state_e     state_q, state_d;
  logic [7:0] skip_q, skip_d;
  logic       start_cap, end_frame;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    start_cap = 1'b0;
    end_frame = 1'b0;
    case (state_q)
      S_IDLE:
        if (vs_rise) begin
          if (SKIP_FRAMES == 0) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_SKIP;
            skip_d  = 8'd0;
          end
        end
      S_SKIP:
        if (vs_rise) begin
          if (skip_q == LAST_SKIP) state_d = S_ARMED;
          else                     skip_d  = skip_q + 8'd1;
        end
      S_ARMED:
        if (vs_fall && Enable) begin
          state_d   = S_CAPT;
          start_cap = 1'b1;
        end
      S_CAPT:
        if (vs_rise) begin
          state_d   = S_ARMED;
          end_frame = 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- beat packing ----------------
  logic          in_cap, beat_en;
  logic [1:0]    phase_q, phase_d, phase_cur;
  logic [PW-1:0] pack_shift;

  assign in_cap    = (state_q == S_CAPT);
  // A beat is dropped if vs rises while Href is still high. This discards
  // the malformed tail of the line.
  assign beat_en   = in_cap & r_href_q & ~vs_rise;
  // The first beat of every line starts a new pixel, whatever was left over.
  assign phase_cur = href_rise ? 2'd0 : phase_q;

  if (PIX_BYTES > 1) begin : g_pack
    logic [PW-DATA_W-1:0] pack_q;
    always_ff @(posedge PCLK) begin
      if (Rst)          pack_q <= '0;
      else if (beat_en) pack_q <= pack_shift[PW-DATA_W-1:0];
    end
    assign pack_shift = {pack_q, r_data_q};
  end else begin : g_nopack
    assign pack_shift = r_data_q;
  end

  // ---------------- line / pixel bookkeeping ----------------
  logic [X_W-1:0] pix_q, pix_d, xo_q, xo_d, len_q, len_d;
  logic [Y_W-1:0] y_q, y_d, yo_q, yo_d;
  logic [PW-1:0]  pixel_q, pixel_d;
  logic           vld_q, vld_d, lerr_q, lerr_d, fd_q, hs_q, vso_q;

  always_comb begin
    phase_d = phase_q;
    pix_d   = pix_q;
    y_d     = y_q;
    vld_d   = 1'b0;
    pixel_d = pixel_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    len_d   = len_q;
    lerr_d  = 1'b0;
    if (start_cap) begin
      phase_d = 2'd0;
      pix_d   = '0;
      y_d     = '0;
    end else if (in_cap) begin
      if (vs_rise && r_href_q) begin
        phase_d = 2'd0;
        pix_d   = '0;
      end else if (r_href_q) begin
        if (phase_cur == LAST_PH) begin
          vld_d   = 1'b1;
          pixel_d = pack_shift;
          xo_d    = pix_q;
          yo_d    = y_q;
          phase_d = 2'd0;
          pix_d   = (pix_q == '1) ? pix_q : pix_q + 1'b1;
        end else begin
          phase_d = phase_cur + 2'd1;
        end
      end else if (href_fall) begin
        lerr_d = (phase_q != 2'd0);
        if (pix_q != '0) begin
          len_d = pix_q;
          y_d   = (y_q == '1) ? y_q : y_q + 1'b1;
        end
        pix_d   = '0;
        phase_d = 2'd0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (Rst) begin
      state_q <= S_IDLE;
      skip_q  <= 8'd0;
      phase_q <= 2'd0;
      pix_q   <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
      pixel_q <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      len_q   <= '0;
      lerr_q  <= 1'b0;
      fd_q    <= 1'b0;
      hs_q    <= 1'b0;
      vso_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      phase_q <= phase_d;
      pix_q   <= pix_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      pixel_q <= pixel_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      len_q   <= len_d;
      lerr_q  <= lerr_d;
      fd_q    <= end_frame;
      hs_q    <= in_cap & r_href_q;
      vso_q   <= (state_d == S_CAPT);
    end
  end

  assign DataValid = vld_q;
  assign DataPixel = pixel_q;
  assign Xaddr     = xo_q;
  assign Yaddr     = yo_q;
  assign DataHs    = hs_q;
  assign DataVs    = vso_q;
  assign FrameDone = fd_q;
  assign LineErr   = lerr_q;
  assign LineLen   = len_q;
  assign State     = state_q;

endmodule
